// File: rtl/axi_req_master_pkg.sv
// axi_req_master_pkg: shared AXI channel types, encodings and default widths for the request master
package axi_req_master_pkg;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;
    localparam int STRB_W = DATA_W / BYTE_W;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_RESP
    } state_e;

    typedef struct packed {
        logic              awvalid;
        logic [ID_W-1:0]   awid;
        logic [ADDR_W-1:0] awaddr;
        logic [7:0]        awlen;
        logic [2:0]        awsize;
        logic [1:0]        awburst;
        logic              wvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wlast;
        logic              bready;
        logic              arvalid;
        logic [ID_W-1:0]   arid;
        logic [ADDR_W-1:0] araddr;
        logic [7:0]        arlen;
        logic [2:0]        arsize;
        logic [1:0]        arburst;
        logic              rready;
    } axis_mosi_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic              bvalid;
        logic [ID_W-1:0]   bid;
        logic [1:0]        bresp;
        logic              arready;
        logic              rvalid;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
    } axis_miso_t;

    // Worst of two responses: the AXI codes are ordered by severity.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi_req_master_if.sv
// axi_req_master_if: native request/stream side and AXI master bus of the request master
interface axi_req_master_if;
    import axi_req_master_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [7:0]        req_len_i;
    logic [ID_W-1:0]   req_id_i;
    logic              wdata_valid_i;
    logic              wdata_ready_o;
    logic [DATA_W-1:0] wdata_i;
    logic [STRB_W-1:0] wstrb_i;
    logic              rdata_valid_o;
    logic              rdata_ready_i;
    logic [DATA_W-1:0] rdata_o;
    logic              rdata_last_o;
    logic              resp_valid_o;
    logic              resp_write_o;
    logic [1:0]        resp_code_o;
    logic              resp_err_o;
    axis_mosi_t        out_mosi_o;
    axis_miso_t        out_miso_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_len_i, req_id_i,
        input  wdata_valid_i, wdata_i, wstrb_i, rdata_ready_i, out_miso_i,
        output req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o,
        output resp_valid_o, resp_write_o, resp_code_o, resp_err_o, out_mosi_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_len_i, req_id_i,
        output wdata_valid_i, wdata_i, wstrb_i, rdata_ready_i, out_miso_i,
        input  req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o,
        input  resp_valid_o, resp_write_o, resp_code_o, resp_err_o, out_mosi_o
    );
endinterface

// File: rtl/axi_req_master.sv
// axi_req_master: turns native read/write requests into single-outstanding AXI INCR bursts
module axi_req_master
    import axi_req_master_pkg::*;
#(
    parameter int ID_WIDTH   = ID_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int BYTE_WIDTH = BYTE_W,
    parameter int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_i,
    axi_req_master_if.master io_bus
);
    localparam logic [2:0] BEAT_SIZE = 3'($clog2(STRB_WIDTH));

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_cnt;
    logic [1:0]            r_code;
    logic                  r_err;
    axis_mosi_t            w_mosi;
    logic                  w_req_ready;
    logic                  w_wdata_ready;
    logic                  w_rdata_valid;
    logic                  w_rdata_last;
    logic                  w_resp_valid;
    logic                  w_last;
    logic                  w_w_hs;
    logic                  w_r_hs;

    // The beat counter is compared before it increments, so len 255 never needs a 9th bit.
    assign w_last = (r_cnt == r_len);
    assign w_w_hs = io_bus.wdata_valid_i && io_bus.out_miso_i.wready;
    assign w_r_hs = io_bus.out_miso_i.rvalid && io_bus.rdata_ready_i;

    // State register; reset aborts any burst without a completion pulse.
    always_ff @(posedge clk_in or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and all channel outputs; payloads come from latched fields so they stay stable while stalled.
    always_comb begin
        w_state_nxt   = r_state;
        w_mosi        = '0;
        w_mosi.awid   = r_id;
        w_mosi.awaddr = r_addr;
        w_mosi.awlen  = r_len;
        w_mosi.awsize = BEAT_SIZE;
        w_mosi.awburst = BURST_INCR;
        w_mosi.arid   = r_id;
        w_mosi.araddr = r_addr;
        w_mosi.arlen  = r_len;
        w_mosi.arsize = BEAT_SIZE;
        w_mosi.arburst = BURST_INCR;
        w_mosi.wdata  = io_bus.wdata_i;
        w_mosi.wstrb  = io_bus.wstrb_i;
        w_req_ready   = 1'b0;
        w_wdata_ready = 1'b0;
        w_rdata_valid = 1'b0;
        w_rdata_last  = 1'b0;
        w_resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = rst_n_i;
                if (io_bus.req_valid_i) w_state_nxt = io_bus.req_write_i ? S_AW : S_AR;
            end
            S_AW: begin
                w_mosi.awvalid = 1'b1;
                if (io_bus.out_miso_i.awready) w_state_nxt = S_W;
            end
            S_W: begin
                w_mosi.wvalid = io_bus.wdata_valid_i;
                w_mosi.wlast  = w_last;
                w_wdata_ready = io_bus.out_miso_i.wready;
                if (w_w_hs && w_last) w_state_nxt = S_B;
            end
            S_B: begin
                w_mosi.bready = 1'b1;
                if (io_bus.out_miso_i.bvalid) w_state_nxt = S_RESP;
            end
            S_AR: begin
                w_mosi.arvalid = 1'b1;
                if (io_bus.out_miso_i.arready) w_state_nxt = S_R;
            end
            S_R: begin
                w_mosi.rready = io_bus.rdata_ready_i;
                w_rdata_valid = io_bus.out_miso_i.rvalid;
                w_rdata_last  = w_last;
                if (w_r_hs && w_last) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, beat counting and response/error accumulation.
    always_ff @(posedge clk_in or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (io_bus.req_valid_i) begin
                    r_write <= io_bus.req_write_i;
                    r_addr  <= io_bus.req_addr_i;
                    r_len   <= io_bus.req_len_i;
                    r_id    <= io_bus.req_id_i;
                    r_code  <= OKAY;
                    r_err   <= 1'b0;
                end
                S_AW, S_AR: r_cnt <= '0;
                S_W: if (w_w_hs) r_cnt <= r_cnt + 8'd1;
                S_B: if (io_bus.out_miso_i.bvalid) begin
                    r_code <= io_bus.out_miso_i.bresp;
                    r_err  <= (io_bus.out_miso_i.bid != r_id);
                end
                S_R: if (w_r_hs) begin
                    r_cnt  <= r_cnt + 8'd1;
                    r_code <= resp_max(r_code, io_bus.out_miso_i.rresp);
                    if ((io_bus.out_miso_i.rlast != w_last) || (io_bus.out_miso_i.rid != r_id)) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.out_mosi_o    = w_mosi;
    assign io_bus.req_ready_o   = w_req_ready;
    assign io_bus.wdata_ready_o = w_wdata_ready;
    assign io_bus.rdata_valid_o = w_rdata_valid;
    assign io_bus.rdata_o       = io_bus.out_miso_i.rdata;
    assign io_bus.rdata_last_o  = w_rdata_last;
    assign io_bus.resp_valid_o  = w_resp_valid;
    assign io_bus.resp_write_o  = r_write;
    assign io_bus.resp_code_o   = r_code;
    assign io_bus.resp_err_o    = r_err;
endmodule
